sr_flipflop_array: RTL and testbench

- Clocked SR flip-flop block: WIDTH independent SR storage bits, each with a complementary output.
- Used as a basic sequential primitive for flag/latch-style state (set by one event, cleared by another) in control logic.
- Default WIDTH=1 is a drop-in single SR flip-flop with outputs q and q_bar.
- All state updates on the rising clock edge; no combinational path from s/r to q.

---
 rtl/sr_pkg.sv | 33 +++
 rtl/sr_bit.sv | 29 ++
 rtl/sr_flipflop_array.sv | 51 +++++
 tb/tb_sr_flipflop_array.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/sr_pkg.sv
// rtl/sr_pkg.sv - shared policy type, constants and next-state helper for SR cells
package sr_pkg;

  typedef logic [1:0] sr_policy_t;

  localparam sr_policy_t POL_HOLD    = 2'd0;
  localparam sr_policy_t POL_TOGGLE  = 2'd1;
  localparam sr_policy_t POL_SET_DOM = 2'd2;
  localparam sr_policy_t POL_RST_DOM = 2'd3;

  // Next value of one SR bit given its current state and requests.
  function automatic logic sr_next(input logic q, input logic s, input logic r,
                                   input sr_policy_t policy);
    logic nxt;
    nxt = q;
    unique case ({s, r})
      2'b00: nxt = q;
      2'b10: nxt = 1'b1;
      2'b01: nxt = 1'b0;
      2'b11: begin
        unique case (policy)
          POL_TOGGLE:  nxt = ~q;
          POL_SET_DOM: nxt = 1'b1;
          POL_RST_DOM: nxt = 1'b0;
          default:     nxt = q;
        endcase
      end
      default: nxt = q;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/sr_bit.sv
// rtl/sr_bit.sv - single clocked SR storage bit with selectable s=r=1 policy
module sr_bit
  import sr_pkg::*;
#(
  parameter sr_policy_t POLICY    = POL_HOLD,
  parameter logic       RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic s,
  input  logic r,
  output logic q
);

  logic q_next;

  always_comb begin
    q_next = sr_next(q, s, r, POLICY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_VAL;
    end else begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/sr_flipflop_array.sv
// rtl/sr_flipflop_array.sv - WIDTH independent clocked SR bits with complementary outputs
// Optional sticky s=r=1 flag per bit when SR_ILLEGAL_FLAG_EN is defined.
module sr_flipflop_array
  import sr_pkg::*;
#(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0,
  parameter int               BOTH_POLICY = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar
`ifdef SR_ILLEGAL_FLAG_EN
  ,
  output logic [WIDTH-1:0] illegal
`endif
);

  // Out-of-range policy values fall back to hold.
  localparam sr_policy_t POLICY =
    (BOTH_POLICY >= 0 && BOTH_POLICY <= 3) ? sr_policy_t'(BOTH_POLICY[1:0]) : POL_HOLD;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sr_bit #(
      .POLICY    (POLICY),
      .RESET_VAL (RESET_VAL[i])
    ) u_bit (
      .clk (clk),
      .rst (rst),
      .s   (s[i]),
      .r   (r[i]),
      .q   (q[i])
    );
  end

  assign q_bar = ~q;

`ifdef SR_ILLEGAL_FLAG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal <= '0;
    end else begin
      illegal <= illegal | (s & r);
    end
  end
`endif

endmodule

// File: tb/tb_sr_flipflop_array.sv
// tb/tb_sr_flipflop_array.sv - directed self-checking bench for sr_flipflop_array
module tb_sr_flipflop_array;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s1 = 1'b0;
  logic       r1 = 1'b0;
  logic [3:0] s4 = 4'b0000;
  logic [3:0] r4 = 4'b0000;

  logic [3:0] q_p, qb_p;
  logic [3:0] q4, qb4;
`ifdef SR_ILLEGAL_FLAG_EN
  logic [3:0] il_p;
  logic [3:0] il4;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar p = 0; p < 4; p++) begin : g_pol
    sr_flipflop_array #(
      .WIDTH       (1),
      .RESET_VAL   (1'b0),
      .BOTH_POLICY (p)
    ) u_dut (
      .clk   (clk),
      .rst   (rst),
      .s     (s1),
      .r     (r1),
      .q     (q_p[p]),
      .q_bar (qb_p[p])
`ifdef SR_ILLEGAL_FLAG_EN
      ,
      .illegal (il_p[p])
`endif
    );
  end

  sr_flipflop_array #(
    .WIDTH       (4),
    .RESET_VAL   (4'b1010),
    .BOTH_POLICY (0)
  ) u_w4 (
    .clk   (clk),
    .rst   (rst),
    .s     (s4),
    .r     (r4),
    .q     (q4),
    .q_bar (qb4)
`ifdef SR_ILLEGAL_FLAG_EN
    ,
    .illegal (il4)
`endif
  );

  task automatic chk(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Order of q_p bits: [3]=reset-dominant, [2]=set-dominant, [1]=toggle, [0]=hold.
  initial begin
    rst = 1'b1; s1 = 1'b0; r1 = 1'b0; s4 = 4'b0000; r4 = 4'b0000;
    tick();
    chk("reset_q",     q_p,  4'b0000);
    chk("reset_qbar",  qb_p, 4'b1111);
    chk("reset_w4_q",  q4,   4'b1010);
    chk("reset_w4_qb", qb4,  4'b0101);

    s1 = 1'b1; s4 = 4'b1111;
    tick();
    chk("reset_over_set_q", q_p, 4'b0000);
    chk("reset_over_set_w4", q4, 4'b1010);
`ifdef SR_ILLEGAL_FLAG_EN
    chk("illegal_after_reset", il_p, 4'b0000);
    chk("illegal_w4_after_reset", il4, 4'b0000);
`endif

    rst = 1'b0; s1 = 1'b1; r1 = 1'b0; s4 = 4'b0001; r4 = 4'b1000;
    tick();
    chk("set_q",     q_p,  4'b1111);
    chk("set_qbar",  qb_p, 4'b0000);
    chk("w4_sr_q",   q4,   4'b0011);
    chk("w4_sr_qb",  qb4,  4'b1100);

    s1 = 1'b0; s4 = 4'b0000; r4 = 4'b0000;
    tick();
    chk("hold1_q", q_p, 4'b1111);
    chk("hold1_w4", q4, 4'b0011);
    tick();
    chk("hold2_q", q_p, 4'b1111);

    r1 = 1'b1; r4 = 4'b0011;
    tick();
    chk("clear1_q",    q_p,  4'b0000);
    chk("clear1_qbar", qb_p, 4'b1111);
    chk("clear_w4",    q4,   4'b0000);
    tick();
    chk("clear2_q",    q_p,  4'b0000);
`ifdef SR_ILLEGAL_FLAG_EN
    chk("illegal_none_yet", il_p, 4'b0000);
`endif

    s1 = 1'b1; r1 = 1'b1; s4 = 4'b1111; r4 = 4'b1111;
    tick();
    chk("both1_q",    q_p,  4'b0110);
    chk("both1_qbar", qb_p, 4'b1001);
    chk("both1_w4",   q4,   4'b0000);
`ifdef SR_ILLEGAL_FLAG_EN
    chk("illegal_set",    il_p, 4'b1111);
    chk("illegal_w4_set", il4,  4'b1111);
`endif
    tick();
    chk("both2_q",    q_p,  4'b0100);
    chk("both2_qbar", qb_p, 4'b1011);
    chk("both2_w4",   q4,   4'b0000);

    s1 = 1'b0; r1 = 1'b0; s4 = 4'b0000; r4 = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("idle_hold_q", q_p, 4'b0100);
`ifdef SR_ILLEGAL_FLAG_EN
      chk("illegal_sticky", il_p, 4'b1111);
      chk("illegal_w4_sticky", il4, 4'b1111);
`endif
    end

    rst = 1'b1;
    tick();
    chk("rereset_q",  q_p, 4'b0000);
    chk("rereset_w4", q4,  4'b1010);
`ifdef SR_ILLEGAL_FLAG_EN
    chk("illegal_cleared",    il_p, 4'b0000);
    chk("illegal_w4_cleared", il4,  4'b0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
